// File: rtl/pivot_div_cell.sv
// Diagonal cell of the LU systolic array: forwards the column pivot, then divides each later element by it.
// Optional macro PIVOT_ROUND_EN: round-to-nearest quotient (saturating) instead of truncation.
module pivot_div_cell #(
    parameter int SZ    = 8,
    parameter int CNT_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SZ-1:0] in_data,
    input  logic          in_first,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SZ-1:0] out_data,
    output logic          out_pivot,
    output logic          div_zero
);

    typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SZ - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t          state_q, state_d;
    logic [SZ-1:0]   pivot_q, pivot_d;
    logic [SZ-1:0]   dividend_q, dividend_d;
    logic [SZ-1:0]   quot_q, quot_d;
    logic [SZ:0]     rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SZ-1:0]   out_data_q, out_data_d;
    logic            out_pivot_q, out_pivot_d;
    logic            div_zero_q, div_zero_d;

    logic [SZ:0]     rem_shift;
    logic [SZ:0]     rem_sub;
    logic            q_bit;
    logic [SZ-1:0]   quot_next;
    logic [SZ-1:0]   quot_final;

    // One restoring step: bring in the next dividend bit, subtract the pivot when it fits.
    always_comb begin
        rem_shift = (rem_q << 1) | {{SZ{1'b0}}, dividend_q[SZ-1]};
        q_bit     = (rem_shift >= {1'b0, pivot_q});
        rem_sub   = q_bit ? (rem_shift - {1'b0, pivot_q}) : rem_shift;
        quot_next = {quot_q[SZ-2:0], q_bit};
    end

`ifdef PIVOT_ROUND_EN
    logic [SZ+1:0] rem_x2;
    logic          round_up;

    always_comb begin
        rem_x2   = {rem_sub, 1'b0};
        round_up = (rem_x2 >= {2'b00, pivot_q});
        if (pivot_q == '0) begin
            quot_final = '1;
        end else if (round_up && (quot_next != '1)) begin
            quot_final = quot_next + {{(SZ-1){1'b0}}, 1'b1};
        end else begin
            quot_final = quot_next;
        end
    end
`else
    always_comb begin
        quot_final = (pivot_q == '0) ? '1 : quot_next;
    end
`endif

    always_comb begin
        state_d     = state_q;
        pivot_d     = pivot_q;
        dividend_d  = dividend_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_pivot_d = out_pivot_q;
        div_zero_d  = div_zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_first) begin
                        pivot_d     = in_data;
                        div_zero_d  = (in_data == '0);
                        out_data_d  = in_data;
                        out_pivot_d = 1'b1;
                        state_d     = OUT;
                    end else begin
                        dividend_d = in_data;
                        rem_d      = '0;
                        quot_d     = '0;
                        cnt_d      = '0;
                        // No pivot since reset leaves pivot_q at zero: flag it too.
                        div_zero_d = (pivot_q == '0);
                        state_d    = DIV;
                    end
                end
            end
            DIV: begin
                rem_d      = rem_sub;
                dividend_d = dividend_q << 1;
                quot_d     = quot_next;
                cnt_d      = cnt_q + CNT_ONE;
                if (cnt_q == LAST_STEP) begin
                    out_data_d  = quot_final;
                    out_pivot_d = 1'b0;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pivot_q     <= '0;
            dividend_q  <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_pivot_q <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pivot_q     <= pivot_d;
            dividend_q  <= dividend_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_pivot_q <= out_pivot_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign out_pivot = out_pivot_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_pivot_div_cell.sv
// Self-checking bench for pivot_div_cell: directed cases plus randomized columns against an arithmetic model.
module tb_pivot_div_cell;

    localparam int SZ = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SZ-1:0] in_data = '0;
    logic          in_first = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SZ-1:0] out_data;
    logic          out_pivot;
    logic          div_zero;

    int n_cmp = 0;
    int n_err = 0;
    int ref_pivot = 0;

    always #5 clk = ~clk;

    pivot_div_cell #(.SZ(SZ), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_first (in_first),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_pivot(out_pivot),
        .div_zero (div_zero)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference quotient straight from integer arithmetic.
    function automatic logic [7:0] ref_quot(input int d, input int p);
        int q;
        if (p == 0) return 8'hFF;
        q = d / p;
`ifdef PIVOT_ROUND_EN
        if (2 * (d % p) >= p) q++;
        if (q > 255) q = 255;
`endif
        return q[7:0];
    endfunction

    // Called at posedge+1 with the cell idle; sends one element and drains its result.
    task automatic send(input logic first, input logic [7:0] d, input int hold);
        logic [7:0] exp;
        int cyc;
        int want_lat;
        if (first) begin
            ref_pivot = d;
            exp = d;
        end else begin
            exp = ref_quot(d, ref_pivot);
        end
        want_lat = first ? 1 : SZ + 1;
        check_val("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_first = first; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_data = 8'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("latency", cyc, want_lat);
        check_val(first ? "pivot_fwd" : "quotient", out_data, exp);
        check_val("out_pivot", out_pivot, first);
        check_val("div_zero", div_zero, ref_pivot == 0);
        check_val("busy_in_ready", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val("hold_valid", out_valid, 1);
            check_val("hold_data", out_data, exp);
            check_val("hold_pivot", out_pivot, first);
            check_val("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("released_valid", out_valid, 0);
        check_val("released_in_ready", in_ready, 1);
        $display("txn first=%0d in=%0d pivot=%0d out=%0d exp=%0d lat=%0d hold=%0d",
                 first, d, ref_pivot, out_data, exp, cyc, hold);
    endtask

    logic [7:0] s_in [5] = '{8'd3, 8'd0, 8'd3, 8'd9, 8'd10};
    logic [7:0] got_q [$];
    logic [7:0] exp_s;
    int idx;
    int pulses;
    int n_el;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_pivot", out_pivot, 0);
        check_val("rst_div_zero", div_zero, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        send(1'b1, 8'd4, 0);
        send(1'b0, 8'd13, 0);
        send(1'b0, 8'd14, 0);
        send(1'b1, 8'd0, 0);
        send(1'b0, 8'd5, 0);
        send(1'b1, 8'd7, 0);
        send(1'b0, 8'd200, 0);
        send(1'b1, 8'd255, 0);
        send(1'b0, 8'd255, 0);
        send(1'b0, 8'd254, 0);
        send(1'b1, 8'd1, 0);
        send(1'b0, 8'd255, 5);
        send(1'b1, 8'd2, 0);
        send(1'b0, 8'd255, 0);
        send(1'b0, 8'd1, 0);

        // Reset in the middle of a divide
        send(1'b1, 8'd5, 0);
        in_valid = 1'b1; in_first = 1'b0; in_data = 8'd100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        ref_pivot = 0;
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_in_ready", in_ready, 1);
        check_val("midrst_div_zero", div_zero, 0);
        check_val("midrst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check_val("midrst_no_pulse", pulses, 0);
        send(1'b0, 8'd9, 0);

        // Streaming column with in_valid held high
        out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 200 && (idx < 5 || got_q.size() < 5); c++) begin
            bit acc;
            if (idx < 5) begin
                in_valid = 1'b1; in_first = (idx == 0); in_data = s_in[idx];
            end else begin
                in_valid = 1'b0; in_first = 1'b0;
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) got_q.push_back(out_data);
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b0;
        ref_pivot = 3;
        check_val("stream_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            exp_s = (i == 0) ? s_in[0] : ref_quot(s_in[i], ref_pivot);
            check_val("stream_out", (got_q.size() > i) ? 32'(got_q[i]) : 32'hDEAD, exp_s);
            $display("txn stream idx=%0d in=%0d exp=%0d", i, s_in[i], exp_s);
        end
        @(posedge clk); #1;

        // Randomized columns
        for (int it = 0; it < 30; it++) begin
            if (it == 0 || $urandom_range(0, 2) == 0)
                send(1'b1, ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255)), 0);
            n_el = $urandom_range(1, 3);
            for (int e = 0; e < n_el; e++)
                send(1'b0, 8'($urandom_range(0, 255)), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
